axis_adapter_cobs_decoder: RTL



---
 rtl/axis_adapter_cobs_decoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axis_adapter_cobs_decoder.sv
// COBS stream decoder: 0x00-delimited encoded bytes in, decoded payload beats out with tlast/tuser.
// Latency: each payload byte leaves one cycle after the next payload byte or delimiter is accepted.
// Backpressure: s_axis_tready = !m_axis_tvalid || m_axis_tready; a stalled output beat holds steady.
module axis_adapter_cobs_decoder #(
    parameter int SYNC_ON_RESET = 1,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic                   frame_error,
    output logic [COUNT_WIDTH-1:0] frames_good,
    output logic [COUNT_WIDTH-1:0] frames_bad
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_CODE  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_RESET = (SYNC_ON_RESET != 0) ? ST_SYNC : ST_CODE;

    logic [1:0]             r_state;
    logic                   r_hold_vld;
    logic [7:0]             r_hold_dat;
    logic [7:0]             r_rem;
    logic                   r_code_ff;
    logic                   r_pend_zero;
    logic [7:0]             r_m_tdata;
    logic                   r_m_tvalid;
    logic                   r_m_tlast;
    logic                   r_m_tuser;
    logic                   r_frame_error;
    logic [COUNT_WIDTH-1:0] r_frames_good;
    logic [COUNT_WIDTH-1:0] r_frames_bad;

    logic       w_accept;
    logic       w_is_delim;
    logic       w_err;
    logic       w_end;
    logic       w_end_good;
    logic       w_end_bad;
    logic       w_push;
    logic [7:0] w_push_dat;
    logic [1:0] w_state_nxt;
    logic [7:0] w_rem_nxt;
    logic       w_code_ff_nxt;
    logic       w_pend_nxt;

    // The output register is always free when a byte is accepted, so no extra skid storage is needed.
    assign s_axis_tready = !r_m_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_is_delim    = (s_axis_tdata == 8'h00);
    // A delimiter arriving mid-block means the block was truncated.
    assign w_err         = (r_state == ST_DATA);
    assign w_end_bad     = w_end && w_err;
    // Empty error-free frames are dropped without being counted.
    assign w_end_good    = w_end && !w_err && r_hold_vld;

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tuser  = r_m_tuser;
    assign frame_error   = r_frame_error;
    assign frames_good   = r_frames_good;
    assign frames_bad    = r_frames_bad;

    // Decode FSM next-state: block code/data tracking, hold pushes and frame end detection.
    always_comb begin
        w_push        = 1'b0;
        w_push_dat    = s_axis_tdata;
        w_end         = 1'b0;
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_code_ff_nxt = r_code_ff;
        w_pend_nxt    = r_pend_zero;
        if (w_accept) begin
            case (r_state)
                ST_SYNC: begin
                    if (w_is_delim) begin
                        w_state_nxt = ST_CODE;
                    end
                end
                ST_CODE: begin
                    if (w_is_delim) begin
                        w_end = 1'b1;
                    end else begin
                        // The implicit zero from the previous block is only materialised once
                        // another block follows; at the delimiter it is the trailing zero.
                        w_push        = r_pend_zero;
                        w_push_dat    = 8'h00;
                        w_rem_nxt     = s_axis_tdata - 8'd1;
                        w_code_ff_nxt = (s_axis_tdata == 8'hFF);
                        w_pend_nxt    = 1'b0;
                        if (s_axis_tdata == 8'h01) begin
                            w_pend_nxt  = 1'b1;
                            w_state_nxt = ST_CODE;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_is_delim) begin
                        w_end = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_rem_nxt = r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            w_pend_nxt  = !r_code_ff;
                            w_state_nxt = ST_CODE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_CODE;
                end
            endcase
        end
        if (w_end) begin
            w_state_nxt = ST_CODE;
            w_rem_nxt   = 8'd0;
            w_pend_nxt  = 1'b0;
        end
    end

    // FSM state, hold register and registered output beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RESET;
            r_hold_vld    <= 1'b0;
            r_hold_dat    <= 8'h00;
            r_rem         <= 8'd0;
            r_code_ff     <= 1'b0;
            r_pend_zero   <= 1'b0;
            r_m_tdata     <= 8'h00;
            r_m_tvalid    <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_m_tuser     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rem         <= w_rem_nxt;
            r_code_ff     <= w_code_ff_nxt;
            r_pend_zero   <= w_pend_nxt;
            r_frame_error <= w_end_bad;
            if (r_m_tvalid && m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_push) begin
                if (r_hold_vld) begin
                    r_m_tdata  <= r_hold_dat;
                    r_m_tvalid <= 1'b1;
                    r_m_tlast  <= 1'b0;
                    r_m_tuser  <= 1'b0;
                end
                r_hold_dat <= w_push_dat;
                r_hold_vld <= 1'b1;
            end
            if (w_end) begin
                if (r_hold_vld) begin
                    r_m_tdata  <= r_hold_dat;
                    r_m_tvalid <= 1'b1;
                    r_m_tlast  <= 1'b1;
                    r_m_tuser  <= w_err;
                end
                r_hold_vld <= 1'b0;
            end
        end
    end

    // Saturating per-frame good/bad counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frames_good <= '0;
            r_frames_bad  <= '0;
        end else begin
            if (w_end_good && (r_frames_good != {COUNT_WIDTH{1'b1}})) begin
                r_frames_good <= r_frames_good + 1'b1;
            end
            if (w_end_bad && (r_frames_bad != {COUNT_WIDTH{1'b1}})) begin
                r_frames_bad <= r_frames_bad + 1'b1;
            end
        end
    end

endmodule
